// File: rtl/router_fsm_pkg.sv
// Shared types and constants for the 1x3 router control FSM.
package router_pkg;

   localparam int ADDR_W    = 2;
   localparam int NUM_PORTS = 3;
   localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      LOAD_PARITY        = 3'd3,
      FIFO_FULL_STATE    = 3'd4,
      LOAD_AFTER_FULL    = 3'd5,
      WAIT_TILL_EMPTY    = 3'd6,
      CHECK_PARITY_ERROR = 3'd7
   } state_t;

   // Picks the per-port flag for an address; the invalid address selects nothing.
   function automatic logic pickPort(input logic [NUM_PORTS-1:0] flags,
                                     input logic [ADDR_W-1:0]    addr);
      case (addr)
         2'd0:    return flags[0];
         2'd1:    return flags[1];
         2'd2:    return flags[2];
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Control bundle between the router FSM, its packet source and the register stage.
interface router_fsm_if;
   import router_pkg::*;

   logic              packet_valid;
   logic [ADDR_W-1:0] datain;
   logic              fifo_full;
   logic              fifo_empty_0;
   logic              fifo_empty_1;
   logic              fifo_empty_2;
   logic              soft_reset_0;
   logic              soft_reset_1;
   logic              soft_reset_2;
   logic              parity_done;
   logic              low_packet_valid;

   logic              detect_add;
   logic              lfd_state;
   logic              ld_state;
   logic              laf_state;
   logic              full_state;
   logic              rst_int_reg;
   logic              write_enb_reg;
   logic              busy;
   logic              drop_pkt;

   modport master (
      output packet_valid, datain, fifo_full,
      output fifo_empty_0, fifo_empty_1, fifo_empty_2,
      output soft_reset_0, soft_reset_1, soft_reset_2,
      output parity_done, low_packet_valid,
      input  detect_add, lfd_state, ld_state, laf_state, full_state,
      input  rst_int_reg, write_enb_reg, busy, drop_pkt
   );

   modport slave (
      input  packet_valid, datain, fifo_full,
      input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
      input  soft_reset_0, soft_reset_1, soft_reset_2,
      input  parity_done, low_packet_valid,
      output detect_add, lfd_state, ld_state, laf_state, full_state,
      output rst_int_reg, write_enb_reg, busy, drop_pkt
   );

endinterface

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 packet router. Define ROUTER_FSM_TIMEOUT_EN to drop
// packets that wait too long in WAIT_TILL_EMPTY (drop_pkt pulses on a drop).
module router_fsm
`ifdef ROUTER_FSM_TIMEOUT_EN
#(
   parameter int TIMEOUT_CYCLES = 30
)
`endif
(
   input  logic        clk,
   input  logic        resetn,
   router_fsm_if.slave bus
);
   import router_pkg::*;

   state_t                r_state;
   state_t                w_nextState;
   logic [ADDR_W-1:0]     r_addr;
   logic [NUM_PORTS-1:0]  w_emptyVec;
   logic [NUM_PORTS-1:0]  w_softVec;
   logic                  w_addrValid;
   logic                  w_selEmpty;
   logic                  w_selSoft;
   logic                  w_timeout;
   logic                  w_drop;

   logic r_detectAdd;
   logic r_lfdState;
   logic r_ldState;
   logic r_lafState;
   logic r_fullState;
   logic r_rstIntReg;
   logic r_writeEnbReg;
   logic r_busy;
   logic r_dropPkt;

   assign w_emptyVec  = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
   assign w_softVec   = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
   assign w_addrValid = (bus.datain != INVALID_ADDR);

   // The header address is only on the bus while decoding; afterwards use the latched one.
   assign w_selEmpty = (r_state == DECODE_ADDRESS) ? pickPort(w_emptyVec, bus.datain)
                                                   : pickPort(w_emptyVec, r_addr);
   assign w_selSoft  = pickPort(w_softVec, r_addr);

`ifdef ROUTER_FSM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_waitCnt;
   logic [CNT_W-1:0] w_waitCntInc;
   assign w_waitCntInc = r_waitCnt + 1'b1;
   assign w_timeout    = (r_state == WAIT_TILL_EMPTY) && (w_waitCntInc == CNT_W'(TIMEOUT_CYCLES));
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_nextState = r_state;
      w_drop      = 1'b0;
      if ((r_state != DECODE_ADDRESS) && w_selSoft) begin
         w_nextState = DECODE_ADDRESS;
      end else begin
         case (r_state)
            DECODE_ADDRESS: begin
               if (bus.packet_valid && w_addrValid)
                  w_nextState = w_selEmpty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: w_nextState = LOAD_DATA;
            LOAD_DATA: begin
               if (bus.fifo_full)
                  w_nextState = FIFO_FULL_STATE;
               else if (!bus.packet_valid)
                  w_nextState = LOAD_PARITY;
            end
            LOAD_PARITY: w_nextState = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
               w_nextState = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            FIFO_FULL_STATE: begin
               if (!bus.fifo_full)
                  w_nextState = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
               if (bus.parity_done)
                  w_nextState = DECODE_ADDRESS;
               else if (bus.low_packet_valid)
                  w_nextState = LOAD_PARITY;
               else
                  w_nextState = LOAD_DATA;
            end
            WAIT_TILL_EMPTY: begin
               // An empty flag arriving together with the timeout still wins.
               if (w_selEmpty) begin
                  w_nextState = LOAD_FIRST_DATA;
               end else if (w_timeout) begin
                  w_nextState = DECODE_ADDRESS;
                  w_drop      = 1'b1;
               end
            end
            default: w_nextState = DECODE_ADDRESS;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= DECODE_ADDRESS;
         r_addr        <= '0;
         r_detectAdd   <= 1'b1;
         r_lfdState    <= 1'b0;
         r_ldState     <= 1'b0;
         r_lafState    <= 1'b0;
         r_fullState   <= 1'b0;
         r_rstIntReg   <= 1'b0;
         r_writeEnbReg <= 1'b0;
         r_busy        <= 1'b0;
         r_dropPkt     <= 1'b0;
`ifdef ROUTER_FSM_TIMEOUT_EN
         r_waitCnt     <= '0;
`endif
      end else begin
         r_state <= w_nextState;
         if ((r_state == DECODE_ADDRESS) && bus.packet_valid && w_addrValid)
            r_addr <= bus.datain;
         r_detectAdd   <= (w_nextState == DECODE_ADDRESS);
         r_lfdState    <= (w_nextState == LOAD_FIRST_DATA);
         r_ldState     <= (w_nextState == LOAD_DATA);
         r_lafState    <= (w_nextState == LOAD_AFTER_FULL);
         r_fullState   <= (w_nextState == FIFO_FULL_STATE);
         r_rstIntReg   <= (w_nextState == CHECK_PARITY_ERROR);
         r_writeEnbReg <= (w_nextState == LOAD_FIRST_DATA) || (w_nextState == LOAD_DATA) ||
                          (w_nextState == LOAD_PARITY)     || (w_nextState == LOAD_AFTER_FULL);
         r_busy        <= (w_nextState != DECODE_ADDRESS) && (w_nextState != LOAD_DATA);
         r_dropPkt     <= w_drop;
`ifdef ROUTER_FSM_TIMEOUT_EN
         if ((r_state == WAIT_TILL_EMPTY) && (w_nextState == WAIT_TILL_EMPTY))
            r_waitCnt <= w_waitCntInc;
         else
            r_waitCnt <= '0;
`endif
      end
   end

   assign bus.detect_add    = r_detectAdd;
   assign bus.lfd_state     = r_lfdState;
   assign bus.ld_state      = r_ldState;
   assign bus.laf_state     = r_lafState;
   assign bus.full_state    = r_fullState;
   assign bus.rst_int_reg   = r_rstIntReg;
   assign bus.write_enb_reg = r_writeEnbReg;
   assign bus.busy          = r_busy;
   assign bus.drop_pkt      = r_dropPkt;

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control FSM for the 1x3 packet router.
- Sits directly upstream of the register/parity stage and drives that stage's control inputs: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg.
- Decodes the 2-bit destination address from the header byte, sequences header/payload/parity loading and stalls on FIFO full.
- Provides busy (source back-pressure) and write_enb_reg (FIFO write strobe).

Parameters:
- ADDR_W, 2, width of the destination address field (datain[1:0]); addresses 0..2 valid, 3 invalid.
- TIMEOUT_CYCLES, 30, WAIT_TILL_EMPTY timeout length; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- packet_valid  in  1  source asserts for the whole packet, deasserts on the parity byte.
- datain  in  2  datain[1:0] of the source bus (header address field).
- fifo_full  in  1  full flag of the currently selected output FIFO.
- fifo_empty_0/1/2  in  1 each  empty flags of FIFOs 0..2.
- soft_reset_0/1/2  in  1 each  per-port soft reset (read timeout) from the sync block.
- parity_done  in  1  from the register stage.
- low_packet_valid  in  1  from the register stage.
- detect_add  out  1  state == DECODE_ADDRESS.
- lfd_state  out  1  state == LOAD_FIRST_DATA.
- ld_state  out  1  state == LOAD_DATA.
- laf_state  out  1  state == LOAD_AFTER_FULL.
- full_state  out  1  state == FIFO_FULL_STATE.
- rst_int_reg  out  1  state == CHECK_PARITY_ERROR.
- write_enb_reg  out  1  state in {LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL}.
- busy  out  1  state not in {DECODE_ADDRESS, LOAD_DATA}.
- drop_pkt  out  1  one-cycle pulse on timeout drop; tied 0 without the optional feature.

Behaviour:
- Single registered state; all outputs are combinational Moore decodes of the state.
- Reset: state = DECODE_ADDRESS, addr_reg = 0. Outputs after reset: detect_add = 1, all others 0.
- addr_reg captures datain[1:0] when state == DECODE_ADDRESS and packet_valid == 1 and datain != 3.
- Selected empty flag = fifo_empty_<addr>: uses datain in DECODE_ADDRESS, addr_reg elsewhere.
- DECODE_ADDRESS:
  - packet_valid, address valid, selected FIFO empty -> LOAD_FIRST_DATA.
  - packet_valid, address valid, selected FIFO not empty -> WAIT_TILL_EMPTY.
  - Otherwise, including address 3 -> stay; the packet is ignored.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally (one cycle; the header is written).
- LOAD_DATA, in priority order:
  - fifo_full -> FIFO_FULL_STATE.
  - !packet_valid -> LOAD_PARITY.
  - Otherwise stay.
- LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL, in priority order:
  - parity_done -> DECODE_ADDRESS.
  - low_packet_valid -> LOAD_PARITY.
  - Otherwise -> LOAD_DATA.
- WAIT_TILL_EMPTY: fifo_empty_<addr_reg> -> LOAD_FIRST_DATA; else stay.
- Soft reset: soft_reset_<addr_reg> asserted in any state other than DECODE_ADDRESS -> DECODE_ADDRESS next cycle.
  - Highest priority over all other transitions.
  - Soft resets of non-selected ports are ignored.
- Asynchronous reset mid-packet: state returns to DECODE_ADDRESS immediately; no partial-packet recovery.
- Latency: header accepted in DECODE_ADDRESS -> lfd_state high the next cycle when the FIFO is empty.

Optional Feature:
- Macro: ROUTER_FSM_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter runs while in WAIT_TILL_EMPTY and clears on any other state.
  - When the count reaches TIMEOUT_CYCLES and the FIFO is still not empty: next state DECODE_ADDRESS and drop_pkt pulses 1 cycle.
  - If the empty flag and the timeout arrive in the same cycle, empty wins (-> LOAD_FIRST_DATA, no drop).
- Not defined: no counter; drop_pkt = 0; WAIT_TILL_EMPTY waits indefinitely.

Decomposition:
- Shared package router_pkg:
  - state enum: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR (3-bit encoding).
  - ADDR_W, NUM_PORTS = 3, INVALID_ADDR = 2'b11.
- No sub-module; the timeout counter stays inline under the macro.

Test Plan:
- Reset released, no traffic -> detect_add = 1, busy = 0, write_enb_reg = 0 held indefinitely.
- Header 8'h0D (addr 1), fifo_empty_1 = 1, 3 payload bytes, then parity:
  - Required sequence: DECODE, LFD, LD x3, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE.
  - write_enb_reg high for 5 cycles; busy high during LFD, LOAD_PARITY, CHECK.
- Header addr 2, fifo_empty_2 = 0 for 4 cycles -> WAIT_TILL_EMPTY for 4 cycles, busy = 1; then fifo_empty_2 = 1 -> lfd_state next cycle.
- fifo_full = 1 during 2nd payload byte for 3 cycles -> full_state 3 cycles, then laf_state 1 cycle, then ld_state resumes. With low_packet_valid = 1 at LAF -> LOAD_PARITY.
- Header 8'h03 (addr 3) with packet_valid -> remains DECODE_ADDRESS, write_enb_reg never asserts.
- addr 0 packet in LOAD_DATA, pulse soft_reset_0 -> DECODE_ADDRESS next cycle; pulse soft_reset_2 instead -> no effect. With ROUTER_FSM_TIMEOUT_EN, WAIT_TILL_EMPTY held 30 cycles -> drop_pkt pulse, DECODE_ADDRESS.
